seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
Multicycle 32-bit integer divider feeding the HI/LO write-back path of the multicycle CPU. It takes operands from the A/B operand registers and produces the remainder (HI) and quotient (LO) for the DIV and DIVU instructions. It uses a start/done handshake with the control FSM, and flags divide-by-zero to the control unit so the exception path can be taken.

Parameters:
WIDTH, 32, operand and result width in bits. Iteration count equals WIDTH.

Ports:
clock  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset
start  input  1  request pulse from control; sampled only in IDLE
is_signed  input  1  1 = DIV (signed), 0 = DIVU (unsigned); sampled with start
a_in  input  WIDTH  dividend, from A register
b_in  input  WIDTH  divisor, from B register
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse; results and div0 are valid
div0  output  1  divide-by-zero flag
hi_out  output  WIDTH  remainder
lo_out  output  WIDTH  quotient

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, done, div0 = 0; hi_out, lo_out = 0; internal count, remainder and quotient registers = 0. Asserting reset during CALC or FIX aborts the operation; no done pulse is produced.
- States: IDLE, CALC, FIX. All outputs are registered.
- IDLE:
  - start=1, b_in==0: at the same edge, done<=1 and div0<=1. State stays IDLE. hi_out and lo_out hold their previous values.
  - start=1, b_in!=0: latch |a| and |b| (magnitudes only when is_signed=1; raw values otherwise). Latch sign_q = a[MSB]^b[MSB] and sign_r = a[MSB] (both forced to 0 when unsigned). Clear the remainder, count=0, div0<=0, busy<=1, state<=CALC.
  - start=0: no action.
- done is a one-cycle pulse in every case; it is cleared at the next edge.
- div0 stays set until the next accepted start.
- CALC, one restoring step per cycle:
  - rem' = {rem[WIDTH-2:0], dvd[MSB]}; shift the dividend left by 1.
  - If rem' >= divisor (unsigned compare, WIDTH+1 bits to avoid overflow), then rem = rem' - divisor and the new quotient bit = 1. Otherwise rem = rem' and the bit = 0.
  - count increments each cycle. After the WIDTH-th step, state<=FIX.
- FIX:
  - lo_out <= sign_q ? -quotient : quotient (two's complement, mod 2^WIDTH).
  - hi_out <= sign_r ? -rem : rem.
  - done<=1, busy<=0, state<=IDLE.
- Latency: with start accepted at edge k, CALC occupies edges k+1..k+WIDTH and FIX is edge k+WIDTH+1. done and results are visible after edge k+WIDTH+1 (33 cycles for WIDTH=32). busy is high after edge k through edge k+WIDTH+1.
- Signed semantics: the quotient truncates toward zero, and the remainder takes the sign of the dividend.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): lo_out=0x80000000, hi_out=0, div0=0. This is the natural result of magnitude arithmetic mod 2^32; there is no extra flag.
- start asserted while busy is ignored; operands are not re-latched.
- hi_out and lo_out change only in FIX (or on reset). They hold between operations, so the CPU can write HI/LO at any cycle after done.
- a_in, b_in and is_signed may change freely after the start edge.

Test Plan:
- Reset: drive reset=0 mid-CALC, then release. Required: busy=0, done=0, div0=0, hi_out=lo_out=0, and no later done pulse.
- Unsigned and signed small values:
  - 7/2, is_signed=0: done 33 cycles after start, lo_out=0x00000003, hi_out=0x00000001.
  - 0xFFFFFFFF/2 unsigned: lo_out=0x7FFFFFFF, hi_out=0x00000001.
- Signed sign handling:
  - -7/2: lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF.
  - 7/-2: lo_out=0xFFFFFFFD, hi_out=0x00000001.
  - -7/-2: lo_out=0x00000003, hi_out=0xFFFFFFFF.
- Corner operands:
  - 0x80000000/0xFFFFFFFF signed: lo_out=0x80000000, hi_out=0, div0=0.
  - 5/9: lo_out=0, hi_out=5.
  - 0/3: lo_out=0, hi_out=0.
- Divide by zero: with prior results lo_out=3, hi_out=1, issue start with b_in=0. Required: done=1 and div0=1 in the next cycle, busy stays 0, and hi_out/lo_out remain 1/3. A following valid start clears div0.
- Handshake: pulse start again 5 cycles into a 100/7 division with different operands. Required: ignored; exactly one done, with lo_out=14, hi_out=2. Then issue back-to-back starts, the second in the cycle after done: the second is accepted and its result arrives 33 cycles later.

Source files
------------

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// seq_divider : multicycle restoring divider producing HI (rem) / LO (quot)
// Revision    : 1.0  initial release
// ============================================================================
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int              C_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [C_CW-1:0] C_LAST = C_CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [C_CW-1:0]  r_count, w_count_nxt;
  logic [WIDTH-1:0] r_rem, w_rem_nxt;
  logic [WIDTH-1:0] r_quot, w_quot_nxt;
  logic [WIDTH-1:0] r_dvd, w_dvd_nxt;
  logic [WIDTH-1:0] r_divisor, w_divisor_nxt;
  logic             r_sign_q, w_sign_q_nxt;
  logic             r_sign_r, w_sign_r_nxt;
  logic             w_busy_nxt, w_done_nxt, w_div0_nxt;
  logic [WIDTH-1:0] w_hi_nxt, w_lo_nxt;

  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  assign w_a_mag  = (is_signed && a_in[WIDTH-1]) ? -a_in : a_in;
  assign w_b_mag  = (is_signed && b_in[WIDTH-1]) ? -b_in : b_in;
  // Extra top bit keeps the shifted remainder exact for divisors above 2^(WIDTH-1)
  assign w_rem_sh = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_divisor};
  assign w_ge     = (w_rem_sh >= {1'b0, r_divisor});

  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_rem_nxt     = r_rem;
    w_quot_nxt    = r_quot;
    w_dvd_nxt     = r_dvd;
    w_divisor_nxt = r_divisor;
    w_sign_q_nxt  = r_sign_q;
    w_sign_r_nxt  = r_sign_r;
    w_busy_nxt    = busy;
    w_done_nxt    = 1'b0;
    w_div0_nxt    = div0;
    w_hi_nxt      = hi_out;
    w_lo_nxt      = lo_out;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (b_in == '0) begin
            w_done_nxt = 1'b1;
            w_div0_nxt = 1'b1;
          end else begin
            w_dvd_nxt     = w_a_mag;
            w_divisor_nxt = w_b_mag;
            w_sign_q_nxt  = is_signed & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
            w_sign_r_nxt  = is_signed & a_in[WIDTH-1];
            w_rem_nxt     = '0;
            w_quot_nxt    = '0;
            w_count_nxt   = '0;
            w_div0_nxt    = 1'b0;
            w_busy_nxt    = 1'b1;
            w_state_nxt   = S_CALC;
          end
        end
      end
      S_CALC: begin
        w_rem_nxt   = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
        w_quot_nxt  = {r_quot[WIDTH-2:0], w_ge};
        w_dvd_nxt   = {r_dvd[WIDTH-2:0], 1'b0};
        w_count_nxt = r_count + 1'b1;
        if (r_count == C_LAST) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        w_lo_nxt    = r_sign_q ? -r_quot : r_quot;
        w_hi_nxt    = r_sign_r ? -r_rem : r_rem;
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_dvd     <= '0;
      r_divisor <= '0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div0      <= 1'b0;
      hi_out    <= '0;
      lo_out    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_rem     <= w_rem_nxt;
      r_quot    <= w_quot_nxt;
      r_dvd     <= w_dvd_nxt;
      r_divisor <= w_divisor_nxt;
      r_sign_q  <= w_sign_q_nxt;
      r_sign_r  <= w_sign_r_nxt;
      busy      <= w_busy_nxt;
      done      <= w_done_nxt;
      div0      <= w_div0_nxt;
      hi_out    <= w_hi_nxt;
      lo_out    <= w_lo_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// tb_seq_divider : scoreboard bench for seq_divider (latency, values, div0)
// Revision       : 1.0  initial release
// ============================================================================
module tb_seq_divider;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy, done, div0;
  logic [W-1:0] hi_out, lo_out;

  seq_divider #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .div0      (div0),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    string        tag;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] d0;
    int           cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  int   dones = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every done pulse consumes one scoreboard entry
  always @(negedge clock) begin
    if (reset === 1'b1 && done === 1'b1) begin
      dones++;
      tests++;
      assert (sbq.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_done: observed done at cycle %0d expected none", cyc);
      end
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        check({mon_e.tag, "_lo"},   lo_out, mon_e.lo);
        check({mon_e.tag, "_hi"},   hi_out, mon_e.hi);
        check({mon_e.tag, "_div0"}, {{(W-1){1'b0}}, div0}, mon_e.d0);
        check({mon_e.tag, "_busy"}, {{(W-1){1'b0}}, busy}, '0);
        check({mon_e.tag, "_cyc"},  cyc, mon_e.cyc);
      end
    end
  end

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    logic [W-1:0] ma, mb, q, r;
    ma = (s && a[W-1]) ? -a : a;
    mb = (s && b[W-1]) ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (s && (a[W-1] ^ b[W-1])) q = -q;
    if (s && a[W-1]) r = -r;
    return {r, q};
  endfunction

  // Called just after a falling edge; start is sampled at the next rising edge
  task automatic issue(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                       input bit push);
    exp_t e;
    a_in = a; b_in = b; is_signed = s; start = 1'b1;
    if (push) begin
      e.tag = tag;
      e.hi  = ehi;
      e.lo  = elo;
      e.d0  = (b == '0) ? 1 : 0;
      e.cyc = cyc + ((b == '0) ? 1 : W + 2);
      sbq.push_back(e);
    end
    @(negedge clock);
    start = 1'b0;
    a_in = $urandom; b_in = $urandom; is_signed = $urandom_range(0, 1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    tests++;
    assert (n < 100) else begin
      fails++;
      $error("FAIL %s_timeout: observed no done in %0d cycles expected done", tag, n);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic rnd(input string tag, input logic s);
    logic [W-1:0]   a, b;
    logic [2*W-1:0] m;
    a = $urandom;
    b = $urandom;
    if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(4, 28);
    if (b == '0) b = 1;
    m = model(a, b, s);
    issue(tag, a, b, s, m[2*W-1:W], m[W-1:0], 1);
    wait_done(tag);
    idle(1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed time limit reached expected completion");
    $fatal(1, "timeout");
  end

  int saved_dones;

  initial begin
    idle(3);
    check("rst_busy", {{(W-1){1'b0}}, busy}, '0);
    check("rst_done", {{(W-1){1'b0}}, done}, '0);
    check("rst_div0", {{(W-1){1'b0}}, div0}, '0);
    check("rst_hi", hi_out, '0);
    check("rst_lo", lo_out, '0);
    reset = 1'b1;
    idle(2);

    issue("u7_2", 32'd7, 32'd2, 1'b0, 32'd1, 32'd3, 1);
    check("u7_2_busy", {{(W-1){1'b0}}, busy}, 1);
    wait_done("u7_2");
    idle(2);

    issue("div0", 32'd9, 32'd0, 1'b0, 32'd1, 32'd3, 1);
    check("div0_busy_now", {{(W-1){1'b0}}, busy}, '0);
    wait_done("div0");
    idle(1);
    check("div0_pulse", {{(W-1){1'b0}}, done}, '0);
    idle(2);
    check("div0_held", {{(W-1){1'b0}}, div0}, 1);
    check("div0_hold_hi", hi_out, 32'd1);
    check("div0_hold_lo", lo_out, 32'd3);

    issue("uffff_2", 32'hFFFF_FFFF, 32'd2, 1'b0, 32'd1, 32'h7FFF_FFFF, 1);
    check("div0_cleared", {{(W-1){1'b0}}, div0}, '0);
    wait_done("uffff_2");
    idle(1);

    issue("sm7_2", -32'sd7, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1);
    wait_done("sm7_2");
    idle(1);
    issue("s7_m2", 32'd7, -32'sd2, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD, 1);
    wait_done("s7_m2");
    idle(1);
    issue("sm7_m2", -32'sd7, -32'sd2, 1'b1, 32'hFFFF_FFFF, 32'h0000_0003, 1);
    wait_done("sm7_m2");
    idle(1);
    issue("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000, 1);
    wait_done("ovf");
    idle(1);
    issue("u5_9", 32'd5, 32'd9, 1'b0, 32'd5, 32'd0, 1);
    wait_done("u5_9");
    idle(1);
    issue("u0_3", 32'd0, 32'd3, 1'b0, 32'd0, 32'd0, 1);
    wait_done("u0_3");
    idle(1);
    issue("ubig", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 32'h7FFF_FFFE, 32'd1, 1);
    wait_done("ubig");
    idle(1);

    saved_dones = dones;
    issue("hs100_7", 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1);
    idle(4);
    issue("ignored", 32'd50, 32'd3, 1'b1, '0, '0, 0);
    wait_done("hs100_7");
    idle(40);
    check("hs_one_done", dones - saved_dones, 1);

    issue("bb1", 32'd123456, 32'd789, 1'b0, 32'd372, 32'd156, 1);
    wait_done("bb1");
    issue("bb2", -32'sd1000, 32'd33, 1'b1, 32'hFFFF_FFF6, 32'hFFFF_FFE2, 1);
    wait_done("bb2");
    idle(1);

    rnd("rnd_u0", 1'b0);
    rnd("rnd_u1", 1'b0);
    rnd("rnd_s0", 1'b1);
    rnd("rnd_s1", 1'b1);

    saved_dones = dones;
    issue("rst_abort", 32'd1000, 32'd3, 1'b0, 32'd1, 32'd333, 1);
    idle(10);
    check("abort_busy", {{(W-1){1'b0}}, busy}, 1);
    #1 reset = 1'b0;
    #1;
    sbq.delete();
    check("abort_busy0", {{(W-1){1'b0}}, busy}, '0);
    check("abort_done0", {{(W-1){1'b0}}, done}, '0);
    check("abort_div00", {{(W-1){1'b0}}, div0}, '0);
    check("abort_hi0", hi_out, '0);
    check("abort_lo0", lo_out, '0);
    @(negedge clock);
    reset = 1'b1;
    idle(45);
    check("abort_no_done", dones - saved_dones, 0);

    check("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
